// File: rtl/wired_iq_sched_static.sv
// Issue-queue controller for static (operand-ready) entries: lowest-free-slot allocation,
// age-matrix oldest-first selection, valid/ready dispatch and issue ports.
module wired_iq_sched_static #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned PAYLOAD_SIZE = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [PAYLOAD_SIZE-1:0]  in_payload_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [PAYLOAD_SIZE-1:0]  out_payload_o,
   output logic [$clog2(DEPTH)-1:0] out_idx_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;

   logic [DEPTH-1:0]        valid;
   logic [DEPTH-1:0]        age [DEPTH];   // age[i][j]: entry i is older than entry j
   logic [PAYLOAD_SIZE-1:0] mem [DEPTH];
   logic [CW-1:0]           count;
   logic [IW-1:0]           free_idx;
   logic [IW-1:0]           sel_idx;
   logic                    found;
   logic                    older;
   logic                    accept;
   logic                    issue;

   assign in_ready_o    = (count < CW'(DEPTH)) && !flush_i;
   assign out_valid_o   = (count != '0) && !flush_i;
   assign accept        = in_valid_i && in_ready_o;
   assign issue         = out_valid_o && out_ready_i;
   assign out_payload_o = mem[sel_idx];
   assign out_idx_o     = sel_idx;
   assign count_o       = count;

   always_comb begin
      free_idx = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!valid[IW'(i)] && !found) begin
            free_idx = IW'(i);
            found    = 1'b1;
         end
      end
   end

   // Stale age bits of empty entries are harmless: only valid rows are consulted.
   always_comb begin
      sel_idx = '0;
      older   = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         older = 1'b0;
         for (int unsigned j = 0; j < DEPTH; j++) begin
            if (valid[IW'(j)] && age[IW'(j)][IW'(i)]) older = 1'b1;
         end
         if (valid[IW'(i)] && !older) sel_idx = IW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) age[IW'(i)] <= '0;
      end else if (flush_i) begin
         valid <= '0;
         count <= '0;
      end else begin
         if (issue) valid[sel_idx] <= 1'b0;
         if (accept) begin
            valid[free_idx] <= 1'b1;
            for (int unsigned j = 0; j < DEPTH; j++) begin
               if (IW'(j) != free_idx) begin
                  age[IW'(j)][free_idx] <= 1'b1;
                  age[free_idx][IW'(j)] <= 1'b0;
               end
            end
         end
         count <= count + CW'(accept) - CW'(issue);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[free_idx] <= in_payload_i;
   end

endmodule

// File: tb/tb_wired_iq_sched_static.sv
// Bench for wired_iq_sched_static: directed scenarios plus random traffic, checked
// against a FIFO-of-entries reference model with lowest-free-slot placement.
module tb_wired_iq_sched_static;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_payload;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_payload;
   logic [1:0]    out_idx;
   logic [2:0]    count;

   wired_iq_sched_static #(.DEPTH(DEPTH), .PAYLOAD_SIZE(PW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_payload_i  (in_payload),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_payload_o (out_payload),
      .out_idx_o     (out_idx),
      .count_o       (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] pl;
      int unsigned   slot;
   } ent_t;

   ent_t          q[$];          // model: entries in age order, oldest first
   logic [DEPTH-1:0] occ;        // model: occupied slots
   logic [PW-1:0] issued[$];     // payloads observed leaving the queue
   int            total = 0;
   int            bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit fl, input bit iv, input logic [PW-1:0] pl, input bit ordy);
      bit          exp_rdy, exp_vld, acc, iss;
      int unsigned slot;
      flush = fl; in_valid = iv; in_payload = pl; out_ready = ordy;
      #3;
      exp_rdy = (q.size() < DEPTH) && !fl;
      exp_vld = (q.size() != 0) && !fl;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_vld));
      chk("count", 32'(count), 32'(q.size()));
      if (q.size() != 0) begin
         chk("out_idx", 32'(out_idx), q[0].slot);
         chk("out_payload", out_payload, q[0].pl);
      end else begin
         chk("out_idx_empty", 32'(out_idx), 32'd0);
      end
      acc = iv && exp_rdy;
      iss = exp_vld && ordy;
      if (iss) issued.push_back(out_payload);
      slot = 0;
      if (acc) begin
         for (int s = DEPTH - 1; s >= 0; s--) if (!occ[s]) slot = s;
      end
      @(posedge clk);
      if (fl) begin
         q.delete();
         occ = '0;
      end else begin
         if (iss) begin
            occ[q[0].slot] = 1'b0;
            void'(q.pop_front());
         end
         if (acc) begin
            occ[slot] = 1'b1;
            q.push_back('{pl, slot});
         end
      end
      #1;
   endtask

   initial begin
      logic [PW-1:0] exp_order [4];
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_payload = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      occ = '0;

      // reset then idle
      repeat (5) step(0, 0, '0, 0);

      // A, B, C accepted while issue is stalled, then drained in order
      step(0, 1, 32'h11, 0);
      step(0, 1, 32'h22, 0);
      step(0, 1, 32'h33, 0);
      chk("count_after_abc", 32'(count), 32'd3);
      chk("payload_after_abc", out_payload, 32'h11);
      issued.delete();
      repeat (3) step(0, 0, '0, 1);
      chk("drain_n", 32'(issued.size()), 32'd3);
      chk("drain_0", issued[0], 32'h11);
      chk("drain_1", issued[1], 32'h22);
      chk("drain_2", issued[2], 32'h33);
      step(0, 0, '0, 0);

      // age must override slot index
      for (int i = 0; i < 4; i++) step(0, 1, 32'hA0 + 32'(i), 0);
      repeat (2) step(0, 0, '0, 1);
      step(0, 1, 32'hB0, 0);
      step(0, 1, 32'hB1, 0);
      issued.delete();
      repeat (4) step(0, 0, '0, 1);
      exp_order = '{32'hA2, 32'hA3, 32'hB0, 32'hB1};
      chk("age_order_n", 32'(issued.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < issued.size()) chk("age_order", issued[i], exp_order[i]);

      // full queue: simultaneous dispatch offer and issue must not accept
      for (int i = 0; i < 4; i++) step(0, 1, 32'hC0 + 32'(i), 0);
      chk("full_ready", 32'(in_ready), 32'd0);
      step(0, 1, 32'hC4, 1);
      chk("full_count_drop", 32'(count), 32'd3);
      step(0, 1, 32'hC4, 0);
      chk("full_count_back", 32'(count), 32'd4);
      repeat (4) step(0, 0, '0, 1);

      // flush with 3 entries outranks accept and issue
      for (int i = 0; i < 3; i++) step(0, 1, 32'hD0 + 32'(i), 0);
      step(1, 1, 32'hEE, 1);
      chk("flush_count", 32'(count), 32'd0);
      step(0, 1, 32'h55, 0);
      issued.delete();
      step(0, 0, '0, 1);
      chk("post_flush_first", (issued.size() != 0) ? issued[0] : 32'hDEAD, 32'h55);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7), $urandom,
              ($urandom_range(0, 1) == 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
